// File: rtl/network.sv
`default_nettype none
// ============================================================================
// network: 8-class 4x5 letter classifier; A = perceptron (w1), B = Hebbian (w2).
// Optional macro NETWORK_SCORE_EN enables the registered s1/s2 score matrices.
// Revision: 1.0
// ============================================================================
module network #(
   parameter int MAX_EPOCH = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       write,
   input  logic       atrain,
   input  logic       gtrain,
   input  logic       goa,
   input  logic       gog,
   input  logic       p,
   input  logic       g,
   input  logic       n,
   input  logic       gn,
   input  logic       on,
   input  logic       noi,
   output logic [7:0] out,
   output int         w1 [8][20],
   output int         w2 [8][20],
   output int         s1 [8][8],
   output int         s2 [8][8],
   output int         itea,
   output int         iteg
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_TRAIN = 2'd1, S_DONE = 2'd2} state_t;

   function automatic logic [19:0] rom(input logic [2:0] i);
      case (i)
         3'd0:    rom = 20'b11111001100110011001;
         3'd1:    rom = 20'b11111000100010001000;
         3'd2:    rom = 20'b10011001111110011001;
         3'd3:    rom = 20'b11111001100110011111;
         3'd4:    rom = 20'b11101000111010001110;
         3'd5:    rom = 20'b01110001011100010111;
         3'd6:    rom = 20'b10011001111100010111;
         default: rom = 20'b11101000100010001000;
      endcase
   endfunction

   state_t      state_a_q, state_a_d, state_b_q, state_b_d;
   logic [2:0]  idx_a_q, idx_a_d;
   logic        err_a_q, err_a_d, err_now;
   int          itea_q, itea_d, iteg_q, iteg_d;
   int          w1_q [8][20];
   int          w1_d [8][20];
   int          w2_q [8][20];
   int          w2_d [8][20];
   logic [7:0]  out_q, out_d;
   logic [2:0]  best_j;
   int          best_v;
   logic [19:0] sel_pat, pat_a, pat_b;
   int          train_sum [8];
   int          cls_a [8];
   int          cls_b [8];

   always_comb begin
      if (p)        sel_pat = rom(3'd0);
      else if (g)   sel_pat = rom(3'd1);
      else if (n)   sel_pat = rom(3'd2);
      else if (gn)  sel_pat = 20'b01111000100010001000;
      else if (on)  sel_pat = rom(3'd3);
      else if (noi) sel_pat = 20'b10101010101010101010;
      else          sel_pat = '0;
   end

   assign pat_a = rom(idx_a_q);
   assign pat_b = rom(iteg_q[2:0]);

   // Bipolar dot products: a set pixel adds the weight, a clear pixel subtracts it.
   always_comb begin
      for (int j = 0; j < 8; j++) begin
         train_sum[j] = 0;
         cls_a[j]     = 0;
         cls_b[j]     = 0;
         for (int k = 0; k < 20; k++) begin
            train_sum[j] = train_sum[j] + (pat_a[k]   ? w1_q[j][k] : -w1_q[j][k]);
            cls_a[j]     = cls_a[j]     + (sel_pat[k] ? w1_q[j][k] : -w1_q[j][k]);
            cls_b[j]     = cls_b[j]     + (sel_pat[k] ? w2_q[j][k] : -w2_q[j][k]);
         end
      end
   end

   always_comb begin
      state_a_d = state_a_q;
      idx_a_d   = idx_a_q;
      err_a_d   = err_a_q;
      itea_d    = itea_q;
      w1_d      = w1_q;
      state_b_d = state_b_q;
      iteg_d    = iteg_q;
      w2_d      = w2_q;
      out_d     = out_q;
      err_now   = 1'b0;
      best_j    = 3'd0;
      best_v    = cls_b[0];

      case (state_a_q)
         S_IDLE, S_DONE: begin
            if (atrain) begin
               state_a_d = S_TRAIN;
               idx_a_d   = 3'd0;
               err_a_d   = 1'b0;
               itea_d    = 0;
            end
         end
         S_TRAIN: begin
            // Weight step is +1 exactly where the target bit equals the pixel bit.
            for (int j = 0; j < 8; j++) begin
               if ((train_sum[j] > 0) != (idx_a_q == 3'(j))) begin
                  err_now = 1'b1;
                  for (int k = 0; k < 20; k++)
                     w1_d[j][k] = w1_q[j][k] + (((idx_a_q == 3'(j)) == pat_a[k]) ? 1 : -1);
               end
            end
            idx_a_d = idx_a_q + 3'd1;
            err_a_d = err_a_q | err_now;
            if (idx_a_q == 3'd7) begin
               itea_d  = itea_q + 1;
               err_a_d = 1'b0;
               if (!(err_a_q || err_now) || (itea_q + 1 == MAX_EPOCH))
                  state_a_d = S_DONE;
            end
         end
         default: state_a_d = S_IDLE;
      endcase

      case (state_b_q)
         S_IDLE: begin
            if (gtrain) begin
               state_b_d = S_TRAIN;
               iteg_d    = 0;
            end
         end
         S_TRAIN: begin
            for (int j = 0; j < 8; j++)
               for (int k = 0; k < 20; k++)
                  w2_d[j][k] = w2_q[j][k] + (((iteg_q[2:0] == 3'(j)) == pat_b[k]) ? 1 : -1);
            iteg_d = iteg_q + 1;
            if (iteg_q == 7)
               state_b_d = S_DONE;
         end
         S_DONE:  state_b_d = S_DONE;
         default: state_b_d = S_IDLE;
      endcase

      if (goa && (state_a_q != S_TRAIN)) begin
         for (int j = 0; j < 8; j++)
            out_d[j] = (cls_a[j] > 0);
      end else if (gog && (state_b_q != S_TRAIN)) begin
         // Strict compare keeps the lowest index on ties.
         for (int j = 1; j < 8; j++) begin
            if (cls_b[j] > best_v) begin
               best_v = cls_b[j];
               best_j = 3'(j);
            end
         end
         out_d = 8'd1 << best_j;
      end

      if (write) begin
         state_a_d = S_IDLE;
         idx_a_d   = 3'd0;
         err_a_d   = 1'b0;
         itea_d    = 0;
         w1_d      = '{default: 0};
         state_b_d = S_IDLE;
         iteg_d    = 0;
         w2_d      = '{default: 0};
         out_d     = 8'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_a_q <= S_IDLE;
         idx_a_q   <= 3'd0;
         err_a_q   <= 1'b0;
         itea_q    <= 0;
         w1_q      <= '{default: 0};
         state_b_q <= S_IDLE;
         iteg_q    <= 0;
         w2_q      <= '{default: 0};
         out_q     <= 8'd0;
      end else begin
         state_a_q <= state_a_d;
         idx_a_q   <= idx_a_d;
         err_a_q   <= err_a_d;
         itea_q    <= itea_d;
         w1_q      <= w1_d;
         state_b_q <= state_b_d;
         iteg_q    <= iteg_d;
         w2_q      <= w2_d;
         out_q     <= out_d;
      end
   end

   assign out  = out_q;
   assign w1   = w1_q;
   assign w2   = w2_q;
   assign itea = itea_q;
   assign iteg = iteg_q;

`ifdef NETWORK_SCORE_EN
   int          s1_q [8][8];
   int          s1_d [8][8];
   int          s2_q [8][8];
   int          s2_d [8][8];
   logic [19:0] score_pat;

   always_comb begin
      score_pat = '0;
      for (int i = 0; i < 8; i++) begin
         score_pat = rom(3'(i));
         for (int j = 0; j < 8; j++) begin
            s1_d[i][j] = 0;
            s2_d[i][j] = 0;
            for (int k = 0; k < 20; k++) begin
               s1_d[i][j] = s1_d[i][j] + (score_pat[k] ? w1_q[j][k] : -w1_q[j][k]);
               s2_d[i][j] = s2_d[i][j] + (score_pat[k] ? w2_q[j][k] : -w2_q[j][k]);
            end
         end
      end
      if (write) begin
         s1_d = '{default: 0};
         s2_d = '{default: 0};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q <= '{default: 0};
         s2_q <= '{default: 0};
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign s1 = s1_q;
   assign s2 = s2_q;
`else
   always_comb begin
      s1 = '{default: 0};
      s2 = '{default: 0};
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_network.sv
`default_nettype none
// ============================================================================
// tb_network: scoreboard bench for network, with a reference model of both nets.
// Revision: 1.0
// ============================================================================
module tb_network;
   localparam int MAX_EPOCH = 100;

   logic       clk = 1'b0;
   logic       reset, write, atrain, gtrain, goa, gog;
   logic       p, g, n, gn, on, noi;
   logic [7:0] out;
   int         w1 [8][20];
   int         w2 [8][20];
   int         s1 [8][8];
   int         s2 [8][8];
   int         itea, iteg;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [19:0] rom_t [8];
   int          m_w1 [8][20];
   int          m_w2 [8][20];
   int          m_itea;
   logic [7:0]  exp_q [$];
   logic [7:0]  last_exp;

   always #5 clk = ~clk;

   network #(.MAX_EPOCH(MAX_EPOCH)) dut (
      .clk(clk), .reset(reset), .write(write), .atrain(atrain), .gtrain(gtrain),
      .goa(goa), .gog(gog), .p(p), .g(g), .n(n), .gn(gn), .on(on), .noi(noi),
      .out(out), .w1(w1), .w2(w2), .s1(s1), .s2(s2), .itea(itea), .iteg(iteg)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int msum(input int net, input int j, input logic [19:0] x);
      int acc, w;
      acc = 0;
      for (int k = 0; k < 20; k++) begin
         w   = (net == 0) ? m_w1[j][k] : m_w2[j][k];
         acc = acc + (x[k] ? w : -w);
      end
      return acc;
   endfunction

   function automatic logic [19:0] sel_pat(input logic [5:0] s);
      if (s[5])      return rom_t[0];
      else if (s[4]) return rom_t[1];
      else if (s[3]) return rom_t[2];
      else if (s[2]) return 20'b01111000100010001000;
      else if (s[1]) return rom_t[3];
      else if (s[0]) return 20'b10101010101010101010;
      return 20'd0;
   endfunction

   task automatic model_train_a();
      bit          err;
      bit          y, t;
      logic [19:0] x;
      m_itea = 0;
      do begin
         err = 1'b0;
         for (int i = 0; i < 8; i++) begin
            x = rom_t[i];
            for (int j = 0; j < 8; j++) begin
               y = (msum(0, j, x) > 0);
               t = (i == j);
               if (y != t) begin
                  err = 1'b1;
                  for (int k = 0; k < 20; k++)
                     m_w1[j][k] += (t ? (x[k] ? 1 : -1) : (x[k] ? -1 : 1));
               end
            end
         end
         m_itea++;
      end while (err && m_itea < MAX_EPOCH);
   endtask

   task automatic model_train_b();
      logic [19:0] x;
      for (int i = 0; i < 8; i++) begin
         x = rom_t[i];
         for (int j = 0; j < 8; j++)
            for (int k = 0; k < 20; k++)
               m_w2[j][k] += (i == j) ? (x[k] ? 1 : -1) : (x[k] ? -1 : 1);
      end
   endtask

   task automatic test_reset();
      int bad;
      n_cmp++;
      if (out !== 8'd0) begin n_fail++; $display("FAIL reset_out: got %h want 00", out); end
      #12 reset = 1'b0;
      write = 1'b1; atrain = 1'b1; gtrain = 1'b1;
      repeat (12) tick();
      write = 1'b0; atrain = 1'b0; gtrain = 1'b0;
      bad = 0;
      for (int j = 0; j < 8; j++)
         for (int k = 0; k < 20; k++)
            if (w1[j][k] != 0 || w2[j][k] != 0) bad++;
      n_cmp++;
      if (bad !== 0) begin n_fail++; $display("FAIL write_weights: %0d nonzero entries, want 0", bad); end
      bad = 0;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            if (s1[i][j] != 0 || s2[i][j] != 0) bad++;
      n_cmp++;
      if (bad !== 0) begin n_fail++; $display("FAIL write_scores: %0d nonzero entries, want 0", bad); end
      n_cmp++;
      if (out !== 8'd0) begin n_fail++; $display("FAIL write_out: got %h want 00", out); end
      n_cmp++;
      if (itea !== 0 || iteg !== 0) begin n_fail++; $display("FAIL write_iters: itea=%0d iteg=%0d want 0/0", itea, iteg); end
      repeat (3) tick();
      n_cmp++;
      if (w1[0][0] !== 0 || itea !== 0 || iteg !== 0)
         begin n_fail++; $display("FAIL write_dominance: w1[0][0]=%0d itea=%0d iteg=%0d want 0", w1[0][0], itea, iteg); end
   endtask

   task automatic test_hebbian();
      int bad;
      gtrain = 1'b1; tick(); gtrain = 1'b0;
      repeat (10) tick();
      model_train_b();
      n_cmp++;
      if (iteg !== 8) begin n_fail++; $display("FAIL hebb_iteg: got %0d want 8", iteg); end
      n_cmp++;
      if (w2[0][19] !== -4) begin n_fail++; $display("FAIL hebb_w2_0_19: got %0d want -4", w2[0][19]); end
      bad = 0;
      for (int j = 0; j < 8; j++)
         for (int k = 0; k < 20; k++)
            if (w2[j][k] != m_w2[j][k]) bad++;
      n_cmp++;
      if (bad !== 0) begin n_fail++; $display("FAIL hebb_w2: %0d entries differ, want 0", bad); end
   endtask

   task automatic test_perceptron();
      int bad, cyc;
      model_train_a();
      atrain = 1'b1; tick(); atrain = 1'b0;
      cyc = 0;
      while (itea != m_itea && cyc < 8 * MAX_EPOCH + 20) begin tick(); cyc++; end
      repeat (2) tick();
      n_cmp++;
      if (itea !== m_itea) begin n_fail++; $display("FAIL perc_itea: got %0d want %0d", itea, m_itea); end
      bad = 0;
      for (int j = 0; j < 8; j++)
         for (int k = 0; k < 20; k++)
            if (w1[j][k] != m_w1[j][k]) bad++;
      n_cmp++;
      if (bad !== 0) begin n_fail++; $display("FAIL perc_w1: %0d entries differ, want 0", bad); end
      bad = 0;
`ifdef NETWORK_SCORE_EN
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            if ((i == j) ? (s1[i][j] <= 0) : (s1[i][j] > 0)) bad++;
      n_cmp++;
      if (bad !== 0) begin n_fail++; $display("FAIL score_s1: %0d entries misclassify, want 0", bad); end
      bad = 0;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            if (s2[i][j] != msum(1, j, rom_t[i])) bad++;
      n_cmp++;
      if (bad !== 0) begin n_fail++; $display("FAIL score_s2: %0d entries differ, want 0", bad); end
`else
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            if (s1[i][j] != 0 || s2[i][j] != 0) bad++;
      n_cmp++;
      if (bad !== 0) begin n_fail++; $display("FAIL score_off: %0d nonzero entries, want 0", bad); end
`endif
   endtask

   task automatic test_classify();
      logic [5:0]  sel_t [11];
      logic [1:0]  go_t  [11];
      logic [19:0] x;
      logic [7:0]  e, got;
      int          best;
      // {p,g,n,gn,on,noi} and {goa,gog}
      sel_t = '{6'b100000, 6'b010000, 6'b001000, 6'b000010, 6'b110000, 6'b100000,
                6'b000100, 6'b000001, 6'b000100, 6'b000000, 6'b001000};
      go_t  = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11,
                2'b01, 2'b01, 2'b10, 2'b01, 2'b00};
      for (int t = 0; t < 11; t++) begin
         {p, g, n, gn, on, noi} = sel_t[t];
         {goa, gog} = go_t[t];
         x = sel_pat(sel_t[t]);
         if (go_t[t][1]) begin
            for (int j = 0; j < 8; j++) e[j] = (msum(0, j, x) > 0);
         end else if (go_t[t][0]) begin
            best = 0;
            for (int j = 1; j < 8; j++) if (msum(1, j, x) > msum(1, best, x)) best = j;
            e = 8'd1 << best;
         end else begin
            e = last_exp;
         end
         exp_q.push_back(e);
         last_exp = e;
         tick();
         got = out;
         e = exp_q.pop_front();
         n_cmp++;
         if (got !== e) begin n_fail++; $display("FAIL classify_%0d: got %b want %b", t, got, e); end
         {p, g, n, gn, on, noi} = 6'd0;
         {goa, gog} = 2'b00;
      end
   endtask

   task automatic test_restart();
      int bad, cyc;
      atrain = 1'b1; tick(); atrain = 1'b0;
      n_cmp++;
      if (itea !== 0) begin n_fail++; $display("FAIL restart_clear: itea=%0d want 0", itea); end
      model_train_a();
      cyc = 0;
      while (itea != m_itea && cyc < 8 * MAX_EPOCH + 20) begin tick(); cyc++; end
      tick();
      bad = 0;
      for (int j = 0; j < 8; j++)
         for (int k = 0; k < 20; k++)
            if (w1[j][k] != m_w1[j][k]) bad++;
      n_cmp++;
      if (bad !== 0 || itea !== m_itea)
         begin n_fail++; $display("FAIL restart_train: %0d w1 diffs itea=%0d want 0 diffs itea=%0d", bad, itea, m_itea); end
   endtask

   task automatic test_reset_mid();
      int         bad;
      logic [7:0] e;
      write = 1'b1; tick(); write = 1'b0;
      p = 1'b1; gog = 1'b1;
      exp_q.push_back(8'b00000001);
      tick();
      p = 1'b0; gog = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if (out !== e) begin n_fail++; $display("FAIL zero_tie: got %b want %b", out, e); end
      atrain = 1'b1; tick(); atrain = 1'b0;
      repeat (11) tick();
      n_cmp++;
      if (itea !== 1) begin n_fail++; $display("FAIL mid_itea: got %0d want 1", itea); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      bad = 0;
      for (int j = 0; j < 8; j++)
         for (int k = 0; k < 20; k++)
            if (w1[j][k] != 0) bad++;
      n_cmp++;
      if (bad !== 0 || itea !== 0 || out !== 8'd0)
         begin n_fail++; $display("FAIL async_reset: w1 nonzero=%0d itea=%0d out=%h want 0", bad, itea, out); end
      #2 reset = 1'b0;
      repeat (5) tick();
      bad = 0;
      for (int j = 0; j < 8; j++)
         for (int k = 0; k < 20; k++)
            if (w1[j][k] != 0) bad++;
      n_cmp++;
      if (bad !== 0 || itea !== 0)
         begin n_fail++; $display("FAIL post_reset_idle: w1 nonzero=%0d itea=%0d want 0", bad, itea); end
   endtask

   initial begin
      reset = 1'b1; write = 1'b0; atrain = 1'b0; gtrain = 1'b0; goa = 1'b0; gog = 1'b0;
      {p, g, n, gn, on, noi} = 6'd0;
      last_exp = 8'd0;
      rom_t[0] = 20'b11111001100110011001;
      rom_t[1] = 20'b11111000100010001000;
      rom_t[2] = 20'b10011001111110011001;
      rom_t[3] = 20'b11111001100110011111;
      rom_t[4] = 20'b11101000111010001110;
      rom_t[5] = 20'b01110001011100010111;
      rom_t[6] = 20'b10011001111100010111;
      rom_t[7] = 20'b11101000100010001000;
      for (int j = 0; j < 8; j++)
         for (int k = 0; k < 20; k++) begin
            m_w1[j][k] = 0;
            m_w2[j][k] = 0;
         end
      #1;
      test_reset();
      test_hebbian();
      test_perceptron();
      test_classify();
      test_restart();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
